// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef logic [15:0] pc_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam pc_t RESET_VECTOR_DFLT = 16'h0000;

endpackage

// File: rtl/inc16bit.sv
// Combinational 16-bit incrementer; wraps FFFF -> 0000, no carry out.
module inc16bit (
  input  logic [15:0] a,
  output logic [15:0] y
);

  assign y = a + 16'd1;

endmodule

// File: rtl/ifu_pc_ctrl.sv
// PC sequencer: one outstanding fetch, valid/ready toward decode, redirects
// from execute override the PC and squash any fetch already in flight.
module ifu_pc_ctrl
  import ifu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr_data,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  ifu_state_e state_q, state_d;
  pc_t        pc_q, pc_d, pc_inc;
  logic       kill_q, kill_d;
  logic       vld_d;
  pc_t        data_d, ipc_d;

  inc16bit u_inc (
    .a (pc_q),
    .y (pc_inc)
  );

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;

  // Next-state and datapath selection; redirect always wins for the pc.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    vld_d   = instr_valid;
    data_d  = instr_data;
    ipc_d   = instr_pc;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_gnt) begin
          state_d = RESP;
          // granted fetch belongs to the old pc once we redirect away
          kill_d  = redirect_valid;
        end
      end
      RESP: begin
        if (!imem_rvalid) begin
          if (redirect_valid) begin
            pc_d   = redirect_pc;
            kill_d = 1'b1;
          end
        end else if (kill_q || redirect_valid) begin
          kill_d  = 1'b0;
          if (redirect_valid) pc_d = redirect_pc;
          state_d = REQ;
        end else begin
          data_d  = imem_rdata;
          ipc_d   = pc_q;
          vld_d   = 1'b1;
          pc_d    = pc_inc;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          vld_d   = 1'b0;
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (instr_ready) begin
          vld_d   = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      kill_q      <= 1'b0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      instr_valid <= vld_d;
      instr_data  <= data_d;
      instr_pc    <= ipc_d;
    end
  end

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Directed bench for ifu_pc_ctrl.
module tb_ifu_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  ifu_pc_ctrl #(.RESET_VECTOR(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one edge, settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From REQ at address a: grant, return rdata, present and accept.
  task automatic fetch(input logic [15:0] a, input logic [15:0] rd, input string tag);
    chk({tag, ".req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, ".addr"}, {16'd0, imem_addr}, {16'd0, a});
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk({tag, ".resp_req"}, {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = rd;
    tick();
    imem_rvalid = 1'b0;
    chk({tag, ".vld"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".data"}, {16'd0, instr_data}, {16'd0, rd});
    chk({tag, ".ipc"}, {16'd0, instr_pc}, {16'd0, a});
    tick();
    chk({tag, ".vld_drop"}, {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic boot_seq(input string tag);
    repeat (3) tick();
    chk({tag, ".rst_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, ".rst_vld"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, ".rst_addr"}, {16'd0, imem_addr}, 32'h0);
    #2 rst_n = 1'b1;
    #1 chk({tag, ".boot_req"}, {31'd0, imem_req}, 32'd0);
    // edge 1 leaves BOOT; the request is sampled by memory on edge 2
    tick();
    chk({tag, ".req_up"}, {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b1;
    #1;
    chk("rst.data", {16'd0, instr_data}, 32'h0);
    chk("rst.ipc", {16'd0, instr_pc}, 32'h0);

    boot_seq("boot");
    fetch(16'h0000, 16'hA5A5, "boot.f0");
    chk("boot.next_addr", {16'd0, imem_addr}, 32'h0001);

    // sequential stream: each fetch exactly 3 edges, no idle gaps
    for (int i = 1; i < 8; i++)
      fetch(i[15:0], 16'h1000 + i[15:0], $sformatf("seq%0d", i));

    // wrap: redirect while waiting for grant
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    fetch(16'hFFFF, 16'hBEEF, "wrap");
    chk("wrap.next", {16'd0, imem_addr}, 32'h0000);

    // redirect during RESP squashes the returning data
    redirect_valid = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    chk("rr.addr", {16'd0, imem_addr}, 32'h0010);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    chk("rr.vld0", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    imem_rvalid = 1'b0;
    chk("rr.vld1", {31'd0, instr_valid}, 32'd0);
    chk("rr.req", {31'd0, imem_req}, 32'd1);
    chk("rr.addr2", {16'd0, imem_addr}, 32'h0200);
    tick();
    chk("rr.vld2", {31'd0, instr_valid}, 32'd0);

    // backpressure in HOLD, redirect on cycle 3
    instr_ready = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 16'h1234;
    tick();
    imem_rvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("bp%0d.vld", c), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("bp%0d.data", c), {16'd0, instr_data}, 32'h1234);
      chk($sformatf("bp%0d.ipc", c), {16'd0, instr_pc}, 32'h0200);
      if (c == 3) begin
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
      end
      tick();
    end
    redirect_valid = 1'b0;
    chk("bp.drop", {31'd0, instr_valid}, 32'd0);
    chk("bp.req", {31'd0, imem_req}, 32'd1);
    chk("bp.addr", {16'd0, imem_addr}, 32'h0040);
    tick();
    tick();
    chk("bp.still", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b1;

    // async reset while in RESP
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("ar.resp", {31'd0, imem_req}, 32'd0);
    chk("ar.addr_pre", {16'd0, imem_addr}, 32'h0040);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.req", {31'd0, imem_req}, 32'd0);
    chk("ar.vld", {31'd0, instr_valid}, 32'd0);
    chk("ar.addr", {16'd0, imem_addr}, 32'h0000);
    boot_seq("reboot");
    fetch(16'h0000, 16'hA5A5, "reboot.f0");
    chk("reboot.next", {16'd0, imem_addr}, 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
